jacob_to_affine: RTL

- Final stage after the Jacobian point-doubling/adding datapath. Takes a Jacobian point (X, Y, Z) over GF(p) and returns the affine point x = X·Z^-2 mod p, y = Y·Z^-3 mod p.
- Sequential design: one binary-inversion engine plus one bit-serial interleaved modular multiplier, reused for four products.
- Consumes the x3/y3/z3/flag outputs of jacob_double / jacob_add. Its own flag starts the next consumer (e.g. scalar-mult controller).

---
 rtl/jacob_to_affine.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/jacob_to_affine.sv
// jacob_to_affine
//   Converts a Jacobian point (X, Y, Z) over GF(p) to affine form:
//     x = X * Z^-2 mod p,  y = Y * Z^-3 mod p.
//   One binary extended-Euclid inversion engine (one step per cycle) is
//   followed by one bit-serial MSB-first interleaved modular multiplier that
//   is reused for four products (zi^2, X*zi^2, zi^3, Y*zi^3).
//
// Ports
//   clk   : rising-edge clock
//   nrst  : asynchronous reset, ACTIVE-HIGH despite the name
//   p     : odd prime modulus, sampled when en is accepted
//   x1,y1,z1 : Jacobian coordinates (< p), sampled when en is accepted
//   en    : start pulse, accepted only in IDLE
//   x, y  : registered affine result
//   inf   : input was the point at infinity (z1 == 0)
//   busy  : operation in progress (includes the DONE cycle)
//   flag  : one-cycle done pulse; x, y, inf valid while it is high
module jacob_to_affine #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] p,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] z1,
  input  logic         en,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         inf,
  output logic         busy,
  output logic         flag
);

  typedef enum logic [1:0] {S_IDLE, S_INV, S_MUL, S_DONE} state_t;

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = $clog2(4 * W + 1);
  // Valid operands finish inversion within 4W steps: every subtraction
  // leaves an even value that is halved next, and halvings are limited by
  // the 2W bits of u and v. The cap also forces degenerate operands out.
  localparam logic [CW-1:0] INV_CAP = CW'(4 * W);

  state_t          state_q, state_d;
  logic [W-1:0]    p_q, p_d;
  logic [W-1:0]    x1_q, x1_d;
  logic [W-1:0]    y1_q, y1_d;
  logic [W-1:0]    u_q, u_d;
  logic [W-1:0]    v_q, v_d;
  logic [W-1:0]    r_q, r_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    zi_q, zi_d;      // zi, later overwritten with zi^3
  logic [W-1:0]    zi2_q, zi2_d;
  logic [W-1:0]    xr_q, xr_d;
  logic [W+1:0]    acc_q, acc_d;
  logic [IW-1:0]   bit_q, bit_d;
  logic [1:0]      step_q, step_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic            inf_q, inf_d;

  logic            inv_done;
  logic [W-1:0]    mul_a, mul_b;
  logic [W+1:0]    mul_nxt;

  // x/2 mod m for odd m; the sum x + m needs one extra bit.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] a,
                                            input logic [W-1:0] m);
    logic [W:0] t;
    t = a[0] ? ({1'b0, a} + {1'b0, m}) : {1'b0, a};
    return t[W:1];
  endfunction

  // (a - b) mod m for a, b < m.
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, m} - {1'b0, b};
    return t[W-1:0];
  endfunction

  // One MSB-first interleaved step: acc = 2*acc (+ b) reduced mod m.
  function automatic logic [W+1:0] mul_step(input logic [W+1:0] acc,
                                            input logic [W-1:0] m,
                                            input logic         abit,
                                            input logic [W-1:0] b);
    logic [W+1:0] t;
    logic [W+1:0] me;
    me = {2'b00, m};
    t  = acc << 1;
    if (t >= me) t = t - me;
    if (abit)    t = t + {2'b00, b};
    if (t >= me) t = t - me;
    return t;
  endfunction

  assign inv_done = (u_q == W'(1)) || (v_q == W'(1)) ||
                    (u_q == '0) || (v_q == '0) || (cnt_q == INV_CAP);

  // Operand routing for the four shared products.
  always_comb begin
    mul_a = zi_q;
    mul_b = zi_q;
    case (step_q)
      2'd0: begin mul_a = zi_q;  mul_b = zi_q;  end
      2'd1: begin mul_a = x1_q;  mul_b = zi2_q; end
      2'd2: begin mul_a = zi2_q; mul_b = zi_q;  end
      default: begin mul_a = y1_q; mul_b = zi_q; end
    endcase
  end

  assign mul_nxt = mul_step(acc_q, p_q, mul_a[bit_q], mul_b);

  // State register
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = (z1 == '0) ? S_DONE : S_INV;
      S_INV:   if (inv_done) state_d = S_MUL;
      S_MUL:   if (step_q == 2'd3 && bit_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    x    = x_q;
    y    = y_q;
    inf  = inf_q;
    busy = (state_q != S_IDLE);
    flag = (state_q == S_DONE);
  end

  // Datapath next values
  always_comb begin
    p_d    = p_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    u_d    = u_q;
    v_d    = v_q;
    r_d    = r_q;
    s_d    = s_q;
    zi_d   = zi_q;
    zi2_d  = zi2_q;
    xr_d   = xr_q;
    acc_d  = acc_q;
    bit_d  = bit_q;
    step_d = step_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    inf_d  = inf_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          p_d    = p;
          x1_d   = x1;
          y1_d   = y1;
          u_d    = z1;
          v_d    = p;
          r_d    = W'(1);
          s_d    = '0;
          cnt_d  = '0;
          acc_d  = '0;
          bit_d  = IW'(W - 1);
          step_d = 2'd0;
          x_d    = '0;
          y_d    = '0;
          inf_d  = (z1 == '0);
        end
      end
      S_INV: begin
        if (inv_done) begin
          // A non-unit exit only happens for degenerate operands.
          if (u_q == W'(1))      zi_d = r_q;
          else if (v_q == W'(1)) zi_d = s_q;
          else                   zi_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            r_d = half_mod(r_q, p_q);
          end else if (!v_q[0]) begin
            v_d = v_q >> 1;
            s_d = half_mod(s_q, p_q);
          end else if (u_q >= v_q) begin
            u_d = u_q - v_q;
            r_d = sub_mod(r_q, s_q, p_q);
          end else begin
            v_d = v_q - u_q;
            s_d = sub_mod(s_q, r_q, p_q);
          end
        end
      end
      S_MUL: begin
        acc_d = mul_nxt;
        bit_d = bit_q - IW'(1);
        if (bit_q == '0) begin
          acc_d  = '0;
          bit_d  = IW'(W - 1);
          step_d = step_q + 2'd1;
          case (step_q)
            2'd0: zi2_d = mul_nxt[W-1:0];
            2'd1: xr_d  = mul_nxt[W-1:0];
            2'd2: zi_d  = mul_nxt[W-1:0];
            default: begin
              x_d = xr_q;
              y_d = mul_nxt[W-1:0];
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      p_q    <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      u_q    <= '0;
      v_q    <= '0;
      r_q    <= '0;
      s_q    <= '0;
      zi_q   <= '0;
      zi2_q  <= '0;
      xr_q   <= '0;
      acc_q  <= '0;
      bit_q  <= '0;
      step_q <= '0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      inf_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      u_q    <= u_d;
      v_q    <= v_d;
      r_q    <= r_d;
      s_q    <= s_d;
      zi_q   <= zi_d;
      zi2_q  <= zi2_d;
      xr_q   <= xr_d;
      acc_q  <= acc_d;
      bit_q  <= bit_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      inf_q  <= inf_d;
    end
  end

endmodule
